// File: rtl/yags_branch_resolver.sv
// Execute-stage resolver for a YAGS predictor: it checkpoints the GHR, restores it on a mispredict and emits PHT/cache updates.
// Define YAGS_STATS_EN to add the saturating n_branch / n_mispredict counters.
module yags_branch_resolver #(
    parameter int GHR_SIZE = 10,
    parameter int PC_SIZE  = 10,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                f_branch,
    input  logic                f_pred,
    output logic [GHR_SIZE-1:0] ghr,
    output logic                full,
    input  logic                ex_valid,
    input  logic                ex_actual,
    input  logic [PC_SIZE-1:0]  ex_pc,
    input  logic                ex_choice,
    input  logic                ex_arr_hit,
    input  logic                ex_arr_pred,
    output logic                flush,
    output logic                redirect_taken,
    output logic                pht_we,
    output logic [PC_SIZE-1:0]  pht_idx,
    output logic                pht_taken,
    output logic                tc_we,
    output logic                nc_we,
    output logic [GHR_SIZE-1:0] c_idx,
    output logic                c_taken,
`ifdef YAGS_STATS_EN
    output logic [CNT_W-1:0]    n_branch,
    output logic [CNT_W-1:0]    n_mispredict,
`endif
    output logic                underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [GHR_SIZE-1:0] cp_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;

    logic                pop_ok, push_ok, mispredict, final_pred;
    logic [GHR_SIZE-1:0] cp;

    assign full       = (count == (PTR_W + 1)'(DEPTH));
    assign pop_ok     = ex_valid && (count != '0);
    assign cp         = cp_mem[rd_ptr];
    assign final_pred = ex_arr_hit ? ex_arr_pred : ex_choice;
    assign mispredict = pop_ok && (ex_actual != final_pred);
    // A push while full is only accepted when a pop frees the slot in the same cycle.
    assign push_ok    = f_branch && !mispredict && (!full || pop_ok);

    // NOTE: checkpoint storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) cp_mem[wr_ptr] <= ghr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            ghr            <= '0;
            flush          <= 1'b0;
            redirect_taken <= 1'b0;
            pht_we         <= 1'b0;
            pht_idx        <= '0;
            pht_taken      <= 1'b0;
            tc_we          <= 1'b0;
            nc_we          <= 1'b0;
            c_idx          <= '0;
            c_taken        <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            flush  <= mispredict;
            pht_we <= pop_ok && !((ex_choice != ex_actual) && ex_arr_hit && (ex_arr_pred == ex_actual));
            tc_we  <= pop_ok && !ex_choice && (ex_arr_hit || ex_actual);
            nc_we  <= pop_ok && ex_choice && (ex_arr_hit || !ex_actual);
            if (ex_valid && (count == '0)) underflow <= 1'b1;

            if (pop_ok) begin
                pht_idx   <= ex_pc;
                pht_taken <= ex_actual;
                c_idx     <= ex_pc ^ cp;
                c_taken   <= ex_actual;
            end

            if (mispredict) begin
                // Every younger checkpoint is wrong-path, so the queue simply restarts empty.
                redirect_taken <= ex_actual;
                ghr            <= {cp[GHR_SIZE-2:0], ex_actual};
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                count          <= '0;
            end else begin
                if (push_ok) begin
                    ghr    <= {ghr[GHR_SIZE-2:0], f_pred};
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
            end
        end
    end

`ifdef YAGS_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_branch     <= '0;
            n_mispredict <= '0;
        end else begin
            if (pop_ok && (n_branch != '1))         n_branch     <= n_branch + CNT_W'(1);
            if (mispredict && (n_mispredict != '1)) n_mispredict <= n_mispredict + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_yags_branch_resolver.sv
// Self-checking bench for yags_branch_resolver: directed test-plan scenarios plus random traffic against a queue-based model.
// Define YAGS_STATS_EN to also check the statistics counters.
module tb_yags_branch_resolver;

    localparam int GHR_SIZE = 10;
    localparam int PC_SIZE  = 10;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                f_branch = 1'b0, f_pred = 1'b0;
    logic                ex_valid = 1'b0, ex_actual = 1'b0, ex_choice = 1'b0;
    logic                ex_arr_hit = 1'b0, ex_arr_pred = 1'b0;
    logic [PC_SIZE-1:0]  ex_pc = '0;
    logic [GHR_SIZE-1:0] ghr, c_idx;
    logic [PC_SIZE-1:0]  pht_idx;
    logic                full, flush, redirect_taken, pht_we, pht_taken;
    logic                tc_we, nc_we, c_taken, underflow;
`ifdef YAGS_STATS_EN
    logic [CNT_W-1:0]    n_branch, n_mispredict;
`endif

    yags_branch_resolver #(
        .GHR_SIZE(GHR_SIZE), .PC_SIZE(PC_SIZE), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .f_branch(f_branch), .f_pred(f_pred), .ghr(ghr), .full(full),
        .ex_valid(ex_valid), .ex_actual(ex_actual), .ex_pc(ex_pc), .ex_choice(ex_choice),
        .ex_arr_hit(ex_arr_hit), .ex_arr_pred(ex_arr_pred), .flush(flush),
        .redirect_taken(redirect_taken), .pht_we(pht_we), .pht_idx(pht_idx),
        .pht_taken(pht_taken), .tc_we(tc_we), .nc_we(nc_we), .c_idx(c_idx), .c_taken(c_taken),
`ifdef YAGS_STATS_EN
        .n_branch(n_branch), .n_mispredict(n_mispredict),
`endif
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: checkpoint list, history as an integer, expected registered outputs.
    int   q[$];
    int   m_ghr;
    bit   e_flush, e_redir, e_pht_we, e_pht_taken, e_tc, e_nc, e_ctaken, e_uf;
    int   e_pht_idx, e_cidx;
    longint e_nb, e_nm;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ghr = 0;
        e_flush = 0; e_redir = 0; e_pht_we = 0; e_pht_taken = 0; e_tc = 0; e_nc = 0;
        e_ctaken = 0; e_uf = 0; e_pht_idx = 0; e_cidx = 0; e_nb = 0; e_nm = 0;
    endtask

    task automatic compare_all();
        check("ghr", 64'(ghr), 64'(m_ghr));
        check("full", 64'(full), 64'(q.size() == DEPTH));
        check("flush", 64'(flush), 64'(e_flush));
        check("pht_we", 64'(pht_we), 64'(e_pht_we));
        check("tc_we", 64'(tc_we), 64'(e_tc));
        check("nc_we", 64'(nc_we), 64'(e_nc));
        check("underflow", 64'(underflow), 64'(e_uf));
        if (e_flush) check("redirect_taken", 64'(redirect_taken), 64'(e_redir));
        if (e_pht_we) begin
            check("pht_idx", 64'(pht_idx), 64'(e_pht_idx));
            check("pht_taken", 64'(pht_taken), 64'(e_pht_taken));
        end
        if (e_tc || e_nc) begin
            check("c_idx", 64'(c_idx), 64'(e_cidx));
            check("c_taken", 64'(c_taken), 64'(e_ctaken));
        end
`ifdef YAGS_STATS_EN
        check("n_branch", 64'(n_branch), 64'(e_nb));
        check("n_mispredict", 64'(n_mispredict), 64'(e_nm));
`endif
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare just after.
    task automatic step(input bit fb, input bit fp, input bit ev, input bit ea,
                        input int pc, input bit ch, input bit hit, input bit ap);
        int sz, cp;
        bit pop, mis;
        @(negedge clk);
        f_branch = fb; f_pred = fp; ex_valid = ev; ex_actual = ea;
        ex_pc = PC_SIZE'(pc); ex_choice = ch; ex_arr_hit = hit; ex_arr_pred = ap;
        @(posedge clk);
        sz  = q.size();
        pop = ev && (sz > 0);
        mis = 0;
        cp  = 0;
        e_flush = 0; e_pht_we = 0; e_tc = 0; e_nc = 0;
        if (ev && sz == 0) e_uf = 1;
        if (pop) begin
            cp  = q[0];
            mis = (ea != (hit ? ap : ch));
            if (e_nb < 64'hFFFF_FFFF) e_nb++;
            e_pht_we    = !((ch != ea) && hit && (ap == ea));
            e_pht_idx   = pc % 1024;
            e_pht_taken = ea;
            e_tc        = !ch && (hit || ea);
            e_nc        = ch && (hit || !ea);
            e_cidx      = (pc % 1024) ^ cp;
            e_ctaken    = ea;
        end
        if (mis) begin
            e_flush = 1;
            e_redir = ea;
            if (e_nm < 64'hFFFF_FFFF) e_nm++;
            m_ghr = (cp * 2 + int'(ea)) % 1024;
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (fb && (sz < DEPTH || pop)) begin
                q.push_back(m_ghr);
                m_ghr = (m_ghr * 2 + int'(fp)) % 1024;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        f_branch = 0; ex_valid = 0;
        model_reset();
        #1;
        check("rst_ghr", 64'(ghr), 64'h0);
        check("rst_full", 64'(full), 64'h0);
        check("rst_underflow", 64'(underflow), 64'h0);
        check("rst_pht_idx", 64'(pht_idx), 64'h0);
        check("rst_c_idx", 64'(c_idx), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Shorthands for the directed part
    task automatic push(input bit p);
        step(1, p, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve_ok(input bit a, input int pc);
        step(0, 0, 1, a, pc, a, 0, 0);
    endtask

    initial begin
        model_reset();
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("idle_flush", 64'(flush), 64'h0);

        // History builds 1,0,1 -> 0x005; correct resolves leave it alone
        push(1); push(0); push(1);
        check("ghr_after_101", 64'(ghr), 64'h005);
        resolve_ok(1, 10); resolve_ok(0, 11); resolve_ok(1, 12);
        check("ghr_after_resolve", 64'(ghr), 64'h005);
        check("flush_after_correct", 64'(flush), 64'h0);

        // Mispredict restores the first checkpoint with the actual outcome
        do_reset();
        push(1); push(1);
        check("ghr_after_11", 64'(ghr), 64'h003);
        step(0, 0, 1, 0, 37, 1, 0, 0);
        check("mp_flush", 64'(flush), 64'h1);
        check("mp_redirect", 64'(redirect_taken), 64'h0);
        check("mp_ghr", 64'(ghr), 64'h000);
        check("mp_nc_we", 64'(nc_we), 64'h1);
        check("mp_pht_we", 64'(pht_we), 64'h1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_one_cycle", 64'(flush), 64'h0);

        // Exception-cache hit with choice overridden: PHT untouched, taken cache refreshed
        push(1); push(0);
        resolve_ok(1, 5);
        step(0, 0, 1, 1, 'h2A5, 0, 1, 1);
        check("hit_pht_we", 64'(pht_we), 64'h0);
        check("hit_tc_we", 64'(tc_we), 64'h1);
        check("hit_c_idx", 64'(c_idx), 64'h2A4);
        check("hit_flush", 64'(flush), 64'h0);

        // Fill to DEPTH, overflow push ignored, then simultaneous pop+push while full
        push(1); push(1); push(1); push(1);
        check("full_set", 64'(full), 64'h1);
        check("ghr_full", 64'(ghr), 64'h02F);
        push(0);
        check("ghr_overflow_ignored", 64'(ghr), 64'h02F);
        step(1, 1, 1, 1, 3, 1, 0, 0);
        check("full_kept", 64'(full), 64'h1);
        check("ghr_pop_push", 64'(ghr), 64'h05F);
        repeat (4) resolve_ok(0, 9);
        check("drained", 64'(full), 64'h0);

        // Random traffic, pops only while the model holds checkpoints
        for (int i = 0; i < 400; i++) begin
            bit fb = ($urandom_range(0, 9) < 7);
            bit ev = ($urandom_range(0, 1) == 1) && (q.size() > 0);
            step(fb, 1'($urandom), ev, 1'($urandom), int'($urandom_range(0, 1023)),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Mid-traffic reset, then mispredict concurrent with a push
        do_reset();
        push(1);
        step(1, 1, 1, 0, 100, 1, 0, 0);
        check("mpp_flush", 64'(flush), 64'h1);
        check("mpp_ghr", 64'(ghr), 64'h000);
        check("mpp_full", 64'(full), 64'h0);
`ifdef YAGS_STATS_EN
        check("mpp_n_branch", 64'(n_branch), 64'h1);
        check("mpp_n_mispredict", 64'(n_mispredict), 64'h1);
`endif
        // Back-to-back resolve after the flush sees an empty queue
        step(0, 0, 1, 1, 7, 1, 0, 0);
        check("uf_set", 64'(underflow), 64'h1);
        check("uf_pht_we", 64'(pht_we), 64'h0);
        check("uf_tc_we", 64'(tc_we), 64'h0);
        check("uf_nc_we", 64'(nc_we), 64'h0);

        // Unconstrained traffic; underflow must stay latched
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 1023)), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        check("uf_sticky", 64'(underflow), 64'h1);

        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("uf_cleared", 64'(underflow), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
